// File: rtl/riscv_pkg.sv
// Shared types and constants for the memory-access stage.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] MEM_SIZE_B       = 2'b00;
  localparam logic [1:0] MEM_SIZE_H       = 2'b01;
  localparam logic [1:0] MEM_SIZE_W       = 2'b10;
  localparam logic [1:0] MEM_SIZE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } mem_state_t;

  // True when an access of this size at this byte offset cannot go to the bus.
  function automatic logic mem_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      MEM_SIZE_B:       bad = 1'b0;
      MEM_SIZE_H:       bad = addr_lo[0];
      MEM_SIZE_W:       bad = |addr_lo;
      MEM_SIZE_ILLEGAL: bad = 1'b1;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and extract/extend for loads.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Store lane replication and byte enables.
  always_comb begin
    wdata = store_data;
    be    = 4'b1111;
    case (size)
      MEM_SIZE_B: begin
        wdata = {4{store_data[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      MEM_SIZE_H: begin
        wdata = {2{store_data[15:0]}};
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata = store_data;
        be    = 4'b1111;
      end
    endcase
  end

  // Load lane selection followed by sign or zero extension.
  always_comb begin
    byte_v = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      MEM_SIZE_B: load_data = is_unsigned ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      MEM_SIZE_H: load_data = is_unsigned ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      default:    load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores on a req/gnt/rvalid bus and registers writeback.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd_addr,
  input  logic [XLEN-1:0] in_rd_data,
  input  logic            in_rd_wen,
  input  logic            in_mem_req,
  input  logic            in_mem_we,
  input  logic [1:0]      in_mem_size,
  input  logic            in_mem_unsigned,
  input  logic [XLEN-1:0] in_store_data,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd_addr,
  output logic [XLEN-1:0] wb_rd_data,
  output logic            wb_rd_wen,
  output logic            misalign_o,
  output logic            bus_err_o
);

  localparam int unsigned CntW = 16;

  mem_state_t state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0] addr_q, sd_q;
  logic [1:0]      size_q;
  logic            uns_q, we_q, rd_wen_q;
  logic [4:0]      rd_addr_q;

  logic            accept, mis, timeout;
  logic [XLEN-1:0] al_wdata, al_load;
  logic [3:0]      al_be;

  assign accept  = in_valid && (state_q == IDLE);
  assign mis     = mem_misaligned(in_mem_size, in_rd_data[1:0]);
  // A zero TIMEOUT_CYC waits forever.
  assign timeout = (TIMEOUT_CYC != 0) && (cnt_q == CntW'(TIMEOUT_CYC - 1));

  lsu_align u_align (
    .size        (size_q),
    .addr_lo     (addr_q[1:0]),
    .is_unsigned (uns_q),
    .store_data  (sd_q),
    .rdata       (dmem_rdata),
    .wdata       (al_wdata),
    .be          (al_be),
    .load_data   (al_load)
  );

  // State and wait counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; gnt/rvalid take priority over a coincident timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && in_mem_req && !mis) state_d = REQ;
      REQ: begin
        if (dmem_gnt)     state_d = we_q ? IDLE : RESP;
        else if (timeout) state_d = IDLE;
      end
      RESP: if (dmem_rvalid || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Counter restarts on every entry to a waiting state.
    cnt_d = (state_d == IDLE || state_d != state_q) ? '0 : cnt_q + 1'b1;
  end

  // Bus and handshake outputs, zeroed outside REQ.
  always_comb begin
    in_ready   = (state_q == IDLE);
    dmem_req   = (state_q == REQ);
    dmem_we    = dmem_req && we_q;
    dmem_addr  = dmem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
    dmem_wdata = dmem_req ? al_wdata : '0;
    dmem_be    = dmem_req ? al_be : 4'b0000;
  end

  // Operand latch for an accepted, aligned memory op.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      sd_q      <= '0;
      size_q    <= MEM_SIZE_B;
      uns_q     <= 1'b0;
      we_q      <= 1'b0;
      rd_addr_q <= '0;
      rd_wen_q  <= 1'b0;
    end else if (accept && in_mem_req && !mis) begin
      addr_q    <= in_rd_data;
      sd_q      <= in_store_data;
      size_q    <= in_mem_size;
      uns_q     <= in_mem_unsigned;
      we_q      <= in_mem_we;
      rd_addr_q <= in_rd_addr;
      rd_wen_q  <= in_rd_wen;
    end
  end

  // Writeback registers; payload only changes when an instruction retires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid   <= 1'b0;
      wb_rd_addr <= '0;
      wb_rd_data <= '0;
      wb_rd_wen  <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      wb_valid   <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept && (!in_mem_req || mis)) begin
            wb_valid   <= 1'b1;
            wb_rd_addr <= in_rd_addr;
            wb_rd_data <= in_rd_data;
            wb_rd_wen  <= !in_mem_req && in_rd_wen && (in_rd_addr != 5'd0);
            misalign_o <= in_mem_req;
          end
        end
        REQ: begin
          if ((dmem_gnt && we_q) || (!dmem_gnt && timeout)) begin
            wb_valid   <= 1'b1;
            wb_rd_addr <= rd_addr_q;
            wb_rd_wen  <= 1'b0;
            bus_err_o  <= !dmem_gnt;
          end
        end
        RESP: begin
          if (dmem_rvalid) begin
            wb_valid   <= 1'b1;
            wb_rd_addr <= rd_addr_q;
            wb_rd_data <= al_load;
            wb_rd_wen  <= rd_wen_q && (rd_addr_q != 5'd0);
          end else if (timeout) begin
            wb_valid   <= 1'b1;
            wb_rd_addr <= rd_addr_q;
            wb_rd_wen  <= 1'b0;
            bus_err_o  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with hand-computed expectations.
module tb_mem_stage;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rd_addr;
  logic [31:0] in_rd_data;
  logic        in_rd_wen, in_mem_req, in_mem_we, in_mem_unsigned;
  logic [1:0]  in_mem_size;
  logic [31:0] in_store_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data;
  logic        wb_rd_wen, misalign_o, bus_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage #(
    .XLEN        (32),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_rd_addr      (in_rd_addr),
    .in_rd_data      (in_rd_data),
    .in_rd_wen       (in_rd_wen),
    .in_mem_req      (in_mem_req),
    .in_mem_we       (in_mem_we),
    .in_mem_size     (in_mem_size),
    .in_mem_unsigned (in_mem_unsigned),
    .in_store_data   (in_store_data),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_be         (dmem_be),
    .dmem_gnt        (dmem_gnt),
    .dmem_rvalid     (dmem_rvalid),
    .dmem_rdata      (dmem_rdata),
    .wb_valid        (wb_valid),
    .wb_rd_addr      (wb_rd_addr),
    .wb_rd_data      (wb_rd_data),
    .wb_rd_wen       (wb_rd_wen),
    .misalign_o      (misalign_o),
    .bus_err_o       (bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid        = 1'b0;
    in_rd_addr      = 5'd0;
    in_rd_data      = 32'd0;
    in_rd_wen       = 1'b0;
    in_mem_req      = 1'b0;
    in_mem_we       = 1'b0;
    in_mem_size     = 2'b00;
    in_mem_unsigned = 1'b0;
    in_store_data   = 32'd0;
  endtask

  task automatic issue_mem(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd);
    in_valid        = 1'b1;
    in_mem_req      = 1'b1;
    in_mem_we       = we;
    in_mem_size     = size;
    in_mem_unsigned = uns;
    in_rd_data      = addr;
    in_store_data   = sd;
    in_rd_addr      = rd;
    in_rd_wen       = !we;
  endtask

  // Load with gnt in the first REQ cycle and rvalid in the first RESP cycle.
  task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] rdata, input logic [4:0] rd,
                         input logic [31:0] exp_data, input logic exp_wen);
    issue_mem(1'b0, size, uns, addr, 32'd0, rd);
    dmem_gnt = 1'b1;
    tick();
    clear_inputs();
    check_eq({tag, " req"}, {31'd0, dmem_req}, 32'd1);
    check_eq({tag, " addr"}, dmem_addr, {addr[31:2], 2'b00});
    check_eq({tag, " busy"}, {31'd0, in_ready}, 32'd0);
    check_eq({tag, " wbv1"}, {31'd0, wb_valid}, 32'd0);
    tick();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    check_eq({tag, " wbv2"}, {31'd0, wb_valid}, 32'd0);
    tick();
    dmem_rvalid = 1'b0;
    check_eq({tag, " wbv3"}, {31'd0, wb_valid}, 32'd1);
    check_eq({tag, " data"}, wb_rd_data, exp_data);
    check_eq({tag, " wen"}, {31'd0, wb_rd_wen}, {31'd0, exp_wen});
    check_eq({tag, " rd"}, {27'd0, wb_rd_addr}, {27'd0, rd});
  endtask

  initial begin
    rst         = 1'b0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'd0;
    clear_inputs();
    #2;
    check_eq("rst in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst req", {31'd0, dmem_req}, 32'd0);
    check_eq("rst wb_valid", {31'd0, wb_valid}, 32'd0);
    check_eq("rst wb_data", wb_rd_data, 32'd0);
    check_eq("rst flags", {30'd0, misalign_o, bus_err_o}, 32'd0);
    #5 rst = 1'b1;
    tick();

    // Non-memory ops back to back, second targets x0.
    in_valid = 1'b1; in_rd_addr = 5'd5; in_rd_data = 32'h0000_1234; in_rd_wen = 1'b1;
    tick();
    check_eq("add wbv", {31'd0, wb_valid}, 32'd1);
    check_eq("add rd", {27'd0, wb_rd_addr}, 32'd5);
    check_eq("add data", wb_rd_data, 32'h0000_1234);
    check_eq("add wen", {31'd0, wb_rd_wen}, 32'd1);
    check_eq("add ready", {31'd0, in_ready}, 32'd1);
    in_rd_addr = 5'd0; in_rd_data = 32'h55;
    tick();
    check_eq("x0 wbv", {31'd0, wb_valid}, 32'd1);
    check_eq("x0 wen", {31'd0, wb_rd_wen}, 32'd0);
    check_eq("x0 data", wb_rd_data, 32'h55);
    clear_inputs();
    tick();
    check_eq("idle wbv", {31'd0, wb_valid}, 32'd0);
    check_eq("idle hold", wb_rd_data, 32'h55);

    do_load("lb",  2'b00, 1'b0, 32'h103, 32'h80FF_0000, 5'd7, 32'hFFFF_FF80, 1'b1);
    do_load("lbu", 2'b00, 1'b1, 32'h103, 32'h80FF_0000, 5'd7, 32'h0000_0080, 1'b1);
    do_load("lh",  2'b01, 1'b0, 32'h102, 32'h8001_1234, 5'd8, 32'hFFFF_8001, 1'b1);
    do_load("lhu", 2'b01, 1'b1, 32'h102, 32'h8001_1234, 5'd8, 32'h0000_8001, 1'b1);
    do_load("lb1", 2'b00, 1'b0, 32'h101, 32'h0000_7F00, 5'd9, 32'h0000_007F, 1'b1);
    do_load("lw0", 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0);

    // SH with gnt held off for 4 cycles.
    issue_mem(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234_ABCD, 5'd9);
    in_rd_wen = 1'b1;
    tick();
    clear_inputs();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) dmem_gnt = 1'b1;
      check_eq("sh req", {31'd0, dmem_req}, 32'd1);
      check_eq("sh we", {31'd0, dmem_we}, 32'd1);
      check_eq("sh addr", dmem_addr, 32'h200);
      check_eq("sh be", {28'd0, dmem_be}, 32'hC);
      check_eq("sh wdata", dmem_wdata, 32'hABCD_ABCD);
      check_eq("sh busy", {31'd0, in_ready}, 32'd0);
      check_eq("sh wbv", {31'd0, wb_valid}, 32'd0);
      tick();
    end
    dmem_gnt = 1'b0;
    check_eq("sh done", {31'd0, wb_valid}, 32'd1);
    check_eq("sh wen", {31'd0, wb_rd_wen}, 32'd0);
    check_eq("sh ready", {31'd0, in_ready}, 32'd1);
    check_eq("sh reqoff", {31'd0, dmem_req}, 32'd0);

    // SB lane 1 and SW full word, both granted immediately.
    issue_mem(1'b1, 2'b00, 1'b0, 32'h001, 32'h0000_005A, 5'd1);
    tick();
    clear_inputs();
    dmem_gnt = 1'b1;
    check_eq("sb be", {28'd0, dmem_be}, 32'h2);
    check_eq("sb wdata", dmem_wdata, 32'h5A5A_5A5A);
    tick();
    dmem_gnt = 1'b0;
    check_eq("sb done", {31'd0, wb_valid}, 32'd1);
    issue_mem(1'b1, 2'b10, 1'b0, 32'h30C, 32'hCAFE_F00D, 5'd1);
    tick();
    clear_inputs();
    dmem_gnt = 1'b1;
    check_eq("sw be", {28'd0, dmem_be}, 32'hF);
    check_eq("sw addr", dmem_addr, 32'h30C);
    check_eq("sw wdata", dmem_wdata, 32'hCAFE_F00D);
    tick();
    dmem_gnt = 1'b0;

    // Misaligned word and illegal size: no bus access, misalign pulse.
    for (int i = 0; i < 2; i++) begin
      if (i == 0) issue_mem(1'b0, 2'b10, 1'b0, 32'h101, 32'd0, 5'd4);
      else        issue_mem(1'b0, 2'b11, 1'b0, 32'h100, 32'd0, 5'd4);
      tick();
      clear_inputs();
      check_eq("mis req", {31'd0, dmem_req}, 32'd0);
      check_eq("mis wbv", {31'd0, wb_valid}, 32'd1);
      check_eq("mis wen", {31'd0, wb_rd_wen}, 32'd0);
      check_eq("mis flag", {31'd0, misalign_o}, 32'd1);
      check_eq("mis ready", {31'd0, in_ready}, 32'd1);
      tick();
      check_eq("mis pulse", {31'd0, misalign_o}, 32'd0);
    end

    // LW never granted: 8 request cycles then abort.
    issue_mem(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 5'd6);
    tick();
    clear_inputs();
    for (int i = 0; i < 8; i++) begin
      check_eq("to req", {31'd0, dmem_req}, 32'd1);
      check_eq("to berr0", {31'd0, bus_err_o}, 32'd0);
      tick();
    end
    check_eq("to reqoff", {31'd0, dmem_req}, 32'd0);
    check_eq("to berr", {31'd0, bus_err_o}, 32'd1);
    check_eq("to wbv", {31'd0, wb_valid}, 32'd1);
    check_eq("to wen", {31'd0, wb_rd_wen}, 32'd0);
    check_eq("to ready", {31'd0, in_ready}, 32'd1);
    tick();
    check_eq("to pulse", {31'd0, bus_err_o}, 32'd0);

    // Async reset while in REQ drops dmem_req without an edge.
    issue_mem(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 5'd6);
    tick();
    clear_inputs();
    check_eq("rreq req", {31'd0, dmem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("rreq drop", {31'd0, dmem_req}, 32'd0);
    check_eq("rreq ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b1;
    tick();

    // Async reset while in RESP; later rvalid must be ignored.
    issue_mem(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 5'd6);
    dmem_gnt = 1'b1;
    tick();
    clear_inputs();
    tick();
    dmem_gnt = 1'b0;
    check_eq("rresp busy", {31'd0, in_ready}, 32'd0);
    #2 rst = 1'b0;
    #1;
    check_eq("rresp req", {31'd0, dmem_req}, 32'd0);
    check_eq("rresp wbv", {31'd0, wb_valid}, 32'd0);
    check_eq("rresp ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1111_1111;
    tick();
    dmem_rvalid = 1'b0;
    check_eq("stale rvalid", {31'd0, wb_valid}, 32'd0);
    in_valid = 1'b1; in_rd_addr = 5'd3; in_rd_data = 32'h77; in_rd_wen = 1'b1;
    tick();
    clear_inputs();
    check_eq("post wbv", {31'd0, wb_valid}, 32'd1);
    check_eq("post data", wb_rd_data, 32'h77);
    do_load("post lw", 2'b10, 1'b0, 32'h400, 32'h0BAD_F00D, 5'd2, 32'h0BAD_F00D, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of ex; consumes ex's rd_addr/rd_data/rd_wen plus load/store controls.
- Performs data-memory loads and stores over a req/gnt/rvalid bus.
- Aligns and extends load data, then presents registered writeback results to regs.
- Back-pressures ex/id_ex via in_ready while a memory transaction is outstanding.

Parameters:
XLEN, 32, datapath/address width (only 32 supported)
TIMEOUT_CYC, 255, max cycles waited for dmem_gnt or dmem_rvalid before abort; 0 disables timeout

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
in_valid  input  1  ex result valid this cycle
in_ready  output  1  stage can accept; transfer when in_valid && in_ready
in_rd_addr  input  5  destination register
in_rd_data  input  32  ALU result; effective address for load/store
in_rd_wen  input  1  register write request
in_mem_req  input  1  instruction is load or store
in_mem_we  input  1  1=store, 0=load
in_mem_size  input  2  00 byte, 01 half, 10 word, 11 illegal
in_mem_unsigned  input  1  zero-extend load (LBU/LHU)
in_store_data  input  32  rs2 value for stores
dmem_req  output  1  bus request
dmem_we  output  1  bus write
dmem_addr  output  32  word-aligned address
dmem_wdata  output  32  replicated store data
dmem_be  output  4  byte enables
dmem_gnt  input  1  request accepted this cycle
dmem_rvalid  input  1  read data valid
dmem_rdata  input  32  read data
wb_valid  output  1  one-cycle pulse per retired instruction
wb_rd_addr  output  5  writeback register
wb_rd_data  output  32  writeback data
wb_rd_wen  output  1  writeback enable, qualified by wb_valid
misalign_o  output  1  one-cycle pulse: misaligned/illegal access
bus_err_o  output  1  one-cycle pulse: timeout abort

Behaviour:
- Reset (rst low, async):
  - state=IDLE.
  - All outputs 0 except in_ready=1.
  - dmem_req drops immediately; any outstanding op is discarded, with no wb_valid.
- FSM states IDLE, REQ, RESP. in_ready = (state==IDLE).
- IDLE, accepted non-memory op:
  - Next edge: wb_valid=1, wb_rd_* = inputs.
  - wb_rd_wen forced 0 if in_rd_addr==0.
  - Stay IDLE; 1-cycle latency, full throughput.
- IDLE, accepted memory op:
  - Alignment check: half requires addr[0]==0; word requires addr[1:0]==0; size 11 is illegal.
  - Misaligned or illegal: no bus access; next edge wb_valid=1, wb_rd_wen=0, misalign_o=1; stay IDLE.
  - Otherwise latch operands and go to REQ.
- REQ:
  - dmem_req=1 with stable dmem_we/addr/wdata/be until dmem_gnt.
  - On gnt, store: wb_valid=1, wb_rd_wen=0; go IDLE.
  - On gnt, load: go RESP.
- RESP: on dmem_rvalid, wb_valid=1 and wb_rd_data = extracted value; go IDLE.
- Load extraction, k=addr[1:0]:
  - byte = rdata[8k+7:8k]; half = rdata[16*addr[1]+15 : 16*addr[1]]; word = rdata.
  - Sign-extended unless in_mem_unsigned.
  - wb_rd_wen = latched rd_wen && rd_addr!=0.
- Store lanes:
  - byte: be = 1<<k, wdata = {4{sd[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011, wdata = {2{sd[15:0]}}.
  - word: be = 1111.
- dmem_addr = {addr[31:2], 2'b00}.
- Timeout:
  - Counter cleared on entry to REQ and to RESP; increments each waiting cycle.
  - When count == TIMEOUT_CYC-1 with no gnt/rvalid: dmem_req=0, bus_err_o=1, wb_valid=1, wb_rd_wen=0; go IDLE.
  - gnt/rvalid arriving in that same cycle wins over the timeout.
- rvalid while in IDLE or REQ: ignored.
- wb_* hold their last value when wb_valid=0; consumers use wb_valid only.
- Best-case load latency: 3 edges (accept→REQ, gnt→RESP, rvalid→wb). Best-case store latency: 2 edges.

Decomposition:
- Package riscv_pkg holds:
  - MEM_SIZE_B/H/W/ILLEGAL constants.
  - mem_state_t enum {IDLE, REQ, RESP}.
  - XLEN.
- Sub-module lsu_align (combinational): store lane/byte-enable generation and load extract/extend; the FSM, counter and wb registers stay in mem_stage.

Test Plan:
- ADD result 0x0000_1234 to rd=5 → next cycle wb_valid=1, wb_rd_addr=5, wb_rd_data=0x1234, wb_rd_wen=1; in_ready never low.
- LB at addr 0x103; gnt same cycle; rvalid next with rdata=0x80FF_0000 → wb_rd_data=0xFFFF_FF80; LBU variant gives 0x0000_0080; wb_valid exactly 3 edges after accept.
- SH at 0x202, sd=0xABCD; gnt delayed 4 cycles → dmem_addr=0x200, be=1100, wdata=0xABCD_ABCD held stable; in_ready low until gnt; wb_rd_wen=0.
- LW at 0x101 → no dmem_req; misalign_o pulse; wb_valid=1 with wb_rd_wen=0; size=11 behaves the same.
- LW with gnt never asserted, TIMEOUT_CYC=8 → dmem_req high 8 cycles then low; bus_err_o pulse; state IDLE.
- rst low while in RESP → dmem_req=0 and wb_valid=0 asynchronously; a later rvalid is ignored; next op proceeds normally.
